// File: rtl/m72_pkg.sv
// rtl/m72_pkg.sv - shared M72 video-path types and constants
// Contents:
//   obj_dma_state_t : object-list DMA states (IDLE, READ, WRITE)
//   OBJ_WORDS       : default sprite attribute list length in 16-bit words
package m72_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2
    } obj_dma_state_t;

    localparam int OBJ_WORDS = 512;

endpackage

// File: rtl/obj_dma.sv
// rtl/obj_dma.sv - object-list DMA, copies object RAM to the sprite buffer on vblank
// Build option: OBJ_DMA_AUTO_EN (defined: every VBLK rise starts a copy, DMA_ON ignored)
// Ports:
//   CLK_32M, RESET            : system clock, asynchronous active-high reset
//   CE_PIX, VBLK              : pixel enable and vertical blank from the timing generator
//   DMA_ON                    : CPU arm strobe (edge-detected)
//   SRC_RD/ADDR/ACK/DATA      : object RAM read port (data valid with ACK)
//   DST_WE/ADDR/DATA          : object buffer write port
//   BUSY                      : transfer in progress
//   OVR                       : pulse when vblank ends before the copy finishes
import m72_pkg::*;

module obj_dma #(
    parameter int WORDS = OBJ_WORDS,
    parameter int AW    = 9
) (
    input  logic          CLK_32M,
    input  logic          RESET,
    input  logic          CE_PIX,
    input  logic          VBLK,
    input  logic          DMA_ON,
    output logic          SRC_RD,
    output logic [AW-1:0] SRC_ADDR,
    input  logic          SRC_ACK,
    input  logic [15:0]   SRC_DATA,
    output logic          DST_WE,
    output logic [AW-1:0] DST_ADDR,
    output logic [15:0]   DST_DATA,
    output logic          BUSY,
    output logic          OVR
);

    localparam logic [AW-1:0] LAST = AW'(WORDS - 1);

    obj_dma_state_t state, state_d;
    logic [AW-1:0]  cnt, cnt_d;
    logic           vblk_q;
    logic           dma_on_q;
    logic           pending;
    logic           vblk_rise;
    logic           vblk_fall;
    logic           dma_rise;
    logic           start_req;

    assign vblk_rise = VBLK & ~vblk_q & CE_PIX;
    assign vblk_fall = ~VBLK & vblk_q & CE_PIX;
    assign dma_rise  = DMA_ON & ~dma_on_q;

`ifdef OBJ_DMA_AUTO_EN
    assign start_req = vblk_rise;
`else
    // A strobe arriving in the very cycle of the VBLK rise still counts.
    assign start_req = vblk_rise & (pending | dma_rise);
`endif

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        case (state)
            IDLE: begin
                if (start_req) begin
                    state_d = READ;
                    cnt_d   = '0;
                end
            end
            READ: begin
                if (SRC_ACK) begin
                    state_d = WRITE;
                end
            end
            WRITE: begin
                if (cnt == LAST) begin
                    state_d = IDLE;
                end else begin
                    cnt_d   = cnt + 1'b1;
                    state_d = READ;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered from the next-state values so they line up
    // with the state they describe without a combinational path.
    always_ff @(posedge CLK_32M or posedge RESET) begin
        if (RESET) begin
            state    <= IDLE;
            cnt      <= '0;
            vblk_q   <= 1'b1;   // no spurious rise if reset releases inside vblank
            dma_on_q <= 1'b0;
            pending  <= 1'b0;
            SRC_RD   <= 1'b0;
            SRC_ADDR <= '0;
            DST_WE   <= 1'b0;
            DST_ADDR <= '0;
            DST_DATA <= '0;
            BUSY     <= 1'b0;
            OVR      <= 1'b0;
        end else begin
            state    <= state_d;
            cnt      <= cnt_d;
            dma_on_q <= DMA_ON;
            if (CE_PIX) begin
                vblk_q <= VBLK;
            end
            // A start consumes the arm; a re-arm during a copy waits for the next rise.
            if (state == IDLE && start_req) begin
                pending <= 1'b0;
            end else if (dma_rise) begin
                pending <= 1'b1;
            end
            SRC_RD   <= (state_d == READ);
            SRC_ADDR <= cnt_d;
            DST_WE   <= (state_d == WRITE);
            DST_ADDR <= cnt_d;
            if (state == READ && SRC_ACK) begin
                DST_DATA <= SRC_DATA;
            end
            BUSY     <= (state_d != IDLE);
            OVR      <= vblk_fall & (state != IDLE);
        end
    end

endmodule

// File: tb/tb_obj_dma.sv
// tb/tb_obj_dma.sv - self-checking bench for obj_dma
module tb_obj_dma;

    localparam int WORDS = m72_pkg::OBJ_WORDS;
    localparam int AW    = 9;
`ifdef OBJ_DMA_AUTO_EN
    localparam logic AUTO = 1'b1;
`else
    localparam logic AUTO = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          ce_pix = 1'b0;
    logic          vblk = 1'b0;
    logic          dma_on = 1'b0;
    logic          src_rd;
    logic [AW-1:0] src_addr;
    logic          src_ack = 1'b0;
    logic [15:0]   src_data = '0;
    logic          dst_we;
    logic [AW-1:0] dst_addr;
    logic [15:0]   dst_data;
    logic          busy;
    logic          ovr;

    obj_dma dut (
        .CLK_32M (clk),
        .RESET   (rst),
        .CE_PIX  (ce_pix),
        .VBLK    (vblk),
        .DMA_ON  (dma_on),
        .SRC_RD  (src_rd),
        .SRC_ADDR(src_addr),
        .SRC_ACK (src_ack),
        .SRC_DATA(src_data),
        .DST_WE  (dst_we),
        .DST_ADDR(dst_addr),
        .DST_DATA(dst_data),
        .BUSY    (busy),
        .OVR     (ovr)
    );

    always #5 clk = ~clk;

    // Reference model state: source RAM image, destination image built from observed writes.
    logic [15:0] src_mem [WORDS];
    logic [15:0] dst_mem [WORDS];

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;
    int ack_delay = 0;

    int wr_cnt, busy_cnt, ovr_cnt, addr_err, stab_err, exp_addr, last_addr;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        ce_pix = (cyc % 4 == 0);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic set_vblk(input logic v);
        tick();
        while (ce_pix !== 1'b1) tick();
        vblk = v;
    endtask

    task automatic arm();
        dma_on = 1'b1;
        tick();
        dma_on = 1'b0;
        tick();
    endtask

    task automatic clear_mon();
        wr_cnt = 0; busy_cnt = 0; ovr_cnt = 0;
        addr_err = 0; stab_err = 0; exp_addr = 0; last_addr = -1;
    endtask

    task automatic new_data();
        for (int i = 0; i < WORDS; i++) begin
            src_mem[i] = 16'($urandom);
            dst_mem[i] = ~src_mem[i];
        end
    endtask

    function automatic int data_errors();
        int e = 0;
        for (int i = 0; i < WORDS; i++)
            if (dst_mem[i] !== src_mem[i]) e++;
        return e;
    endfunction

    task automatic wait_done(input string tag);
        int n = 0;
        while (busy === 1'b1 && n < 4000) begin
            tick();
            n++;
        end
        check(tag, busy, 0);
    endtask

    task automatic wait_words(input int w, input string tag);
        int n = 0;
        while (wr_cnt < w && n < 4000) begin
            tick();
            n++;
        end
        check(tag, (wr_cnt >= w), 1);
    endtask

    // Monitor and object-RAM responder, both sampling on the falling edge.
    initial begin
        int rd_cycles = 0;
        logic [AW-1:0] held_addr = '0;
        forever begin
            @(negedge clk);
            if (dst_we === 1'b1) begin
                if (int'(dst_addr) != exp_addr) addr_err++;
                dst_mem[dst_addr] = dst_data;
                wr_cnt++;
                exp_addr  = int'(dst_addr) + 1;
                last_addr = int'(dst_addr);
            end
            if (busy === 1'b1) busy_cnt++;
            if (ovr === 1'b1) ovr_cnt++;
            if (src_rd === 1'b1) begin
                rd_cycles++;
                if (rd_cycles > 1 && src_addr !== held_addr) stab_err++;
                held_addr = src_addr;
                src_ack  = (rd_cycles > ack_delay);
                src_data = src_mem[src_addr];
                if (src_ack) rd_cycles = 0;
            end else begin
                rd_cycles = 0;
                // Junk ACKs with no read outstanding must be ignored.
                src_ack  = 1'($urandom);
                src_data = 16'($urandom);
            end
        end
    end

    initial begin
        clear_mon();
        new_data();
        rst = 1'b1;
        ticks(4);
        check("rst_src_rd",   src_rd,   0);
        check("rst_src_addr", src_addr, 0);
        check("rst_dst_we",   dst_we,   0);
        check("rst_dst_addr", dst_addr, 0);
        check("rst_dst_data", dst_data, 0);
        check("rst_busy",     busy,     0);
        check("rst_ovr",      ovr,      0);
        rst = 1'b0;
        ticks(8);

        // Full copy with immediate ACK.
        ack_delay = 0;
        new_data();
        clear_mon();
        arm();
        set_vblk(1'b1);
        check("t1_pre_start", src_rd, 0);
        tick();
        check("t1_start_rd",   src_rd,   1);
        check("t1_start_busy", busy,     1);
        check("t1_start_addr", src_addr, 0);
        wait_done("t1_timeout");
        check("t1_writes",    wr_cnt,    WORDS);
        check("t1_addr_seq",  addr_err,  0);
        check("t1_data",      data_errors(), 0);
        check("t1_busy_cyc",  busy_cnt,  2 * WORDS);
        check("t1_ovr",       ovr_cnt,   0);
        check("t1_last_addr", last_addr, WORDS - 1);
        set_vblk(1'b0);

        // VBLK rise with no arm.
        new_data();
        clear_mon();
        set_vblk(1'b1);
        ticks(40);
        check("t2_busy", busy, AUTO);
        wait_done("t2_timeout");
        check("t2_writes", wr_cnt, AUTO ? WORDS : 0);
        set_vblk(1'b0);

        // Slow ACK: three wait cycles per word.
        ack_delay = 3;
        new_data();
        clear_mon();
        arm();
        set_vblk(1'b1);
        tick();
        wait_done("t3_timeout");
        check("t3_writes",   wr_cnt,   WORDS);
        check("t3_busy_cyc", busy_cnt, 5 * WORDS);
        check("t3_addr_hold", stab_err, 0);
        check("t3_data",     data_errors(), 0);
        set_vblk(1'b0);

        // Re-arm during a copy is served on the following vblank only.
        ack_delay = 0;
        new_data();
        clear_mon();
        arm();
        set_vblk(1'b1);
        tick();
        wait_words(100, "t4_w100_timeout");
        arm();
        wait_done("t4_timeout");
        check("t4_writes", wr_cnt, WORDS);
        check("t4_data",   data_errors(), 0);
        ticks(50);
        check("t4_no_restart", busy, 0);
        new_data();
        clear_mon();
        set_vblk(1'b0);
        set_vblk(1'b1);
        tick();
        check("t4_second_start", src_rd, 1);
        wait_done("t4b_timeout");
        check("t4b_writes", wr_cnt, WORDS);
        check("t4b_data",   data_errors(), 0);
        set_vblk(1'b0);

        // VBLK ends mid-copy.
        ack_delay = 3;
        new_data();
        clear_mon();
        arm();
        set_vblk(1'b1);
        tick();
        wait_words(300, "t5_w300_timeout");
        set_vblk(1'b0);
        wait_done("t5_timeout");
        check("t5_ovr",       ovr_cnt,   1);
        check("t5_writes",    wr_cnt,    WORDS);
        check("t5_last_addr", last_addr, WORDS - 1);
        check("t5_data",      data_errors(), 0);

        // Reset mid-copy.
        ack_delay = 0;
        new_data();
        clear_mon();
        arm();
        set_vblk(1'b1);
        tick();
        wait_words(50, "t6_w50_timeout");
        rst = 1'b1;
        #1;
        check("t6_rst_we",   dst_we, 0);
        check("t6_rst_busy", busy,   0);
        ticks(3);
        rst = 1'b0;
        clear_mon();
        ticks(40);
        check("t6_no_spurious", busy_cnt, 0);
        set_vblk(1'b0);
        set_vblk(1'b1);
        ticks(20);
        check("t6_unarmed_rise", busy, AUTO);
        wait_done("t6a_timeout");
        set_vblk(1'b0);
        new_data();
        clear_mon();
        arm();
        set_vblk(1'b1);
        tick();
        check("t6_rearm_start", src_rd, 1);
        wait_done("t6b_timeout");
        check("t6_writes", wr_cnt, WORDS);
        check("t6_data",   data_errors(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/obj_dma.md
# obj_dma

Object-list DMA for the M72 video path. It sits directly downstream of the raster timing generator and consumes its `VBLK` output. When the CPU arms a transfer, it copies the sprite attribute list from CPU-visible object RAM into the sprite renderer's private object buffer. The copy starts on the next vertical-blank rising edge, so the renderer never sees a half-updated list during active display.

## Interface
Parameters:
- `WORDS`, default 512: number of 16-bit words per transfer.
- `AW`, default 9: address width; must satisfy 2^AW >= WORDS.

Ports:
- `CLK_32M`, in, 1: system clock.
- `RESET`, in, 1: reset, asynchronous and active-high.
- `CE_PIX`, in, 1: pixel clock enable. Used only for VBLK edge qualification.
- `VBLK`, in, 1: vertical blank from the timing generator. Changes only on `CE_PIX` cycles.
- `DMA_ON`, in, 1: CPU strobe that arms a transfer. Single-cycle or level; edge-detected.
- `SRC_RD`, out, 1: object RAM read request.
- `SRC_ADDR`, out, AW: object RAM word address.
- `SRC_ACK`, in, 1: read acknowledge; `SRC_DATA` is valid in the same cycle.
- `SRC_DATA`, in, 16: object RAM read data.
- `DST_WE`, out, 1: object buffer write enable.
- `DST_ADDR`, out, AW: object buffer word address.
- `DST_DATA`, out, 16: object buffer write data.
- `BUSY`, out, 1: high while a transfer is in progress (any state from READ through WRITE).
- `OVR`, out, 1: one-cycle pulse when VBLK falls before the transfer completes.

## Operation
- `pending` is set on the rising edge of `DMA_ON`. It is cleared on the cycle the transfer starts.
- A VBLK rise is detected as `VBLK & ~vblk_q & CE_PIX`, where `vblk_q` is updated on `CE_PIX`.
- States:
  - IDLE: leave on a VBLK rise with `pending` (or rising `DMA_ON` in the same cycle). Go to READ, `cnt`=0.
  - READ: `SRC_RD`=1, `SRC_ADDR`=`cnt`. Hold until `SRC_ACK`. On ACK, capture `SRC_DATA` and go to WRITE.
  - WRITE: `DST_WE`=1, `DST_ADDR`=`cnt`, `DST_DATA`=captured word.
    - If `cnt`==WORDS-1, go to IDLE.
    - Otherwise increment `cnt` and go to READ.
- `cnt` is AW bits wide; the terminal compare is against WORDS-1, so there is never any wrap-around.
- `DMA_ON` rising during a transfer sets `pending` again. That re-arm is served on the next VBLK rise, never the current one.
- VBLK falling while BUSY: the transfer continues to completion and `OVR` pulses once, on the falling-edge cycle.
- A VBLK rise while BUSY is ignored (this is only possible when WORDS is oversized).
- RESET asserted mid-transfer:
  - Immediately: state=IDLE, `pending`=0, `cnt`=0, `vblk_q`=1.
  - The `vblk_q`=1 reset value prevents a spurious start if reset releases during vblank.
  - The object buffer keeps its partial contents.

## Timing
- Reset values: `SRC_RD`=0, `SRC_ADDR`=0, `DST_WE`=0, `DST_ADDR`=0, `DST_DATA`=0, `BUSY`=0, `OVR`=0.
- All outputs are registered.
- Start latency: `SRC_RD` rises on the clock after the qualifying VBLK-rise cycle.
- ACK handling: an ACK in cycle N gives `DST_WE` in cycle N+1 and the next `SRC_RD` in cycle N+2.
- Minimum 2 cycles per word, so a 512-word transfer takes at least 1024 `CLK_32M` cycles (about 32 µs). That is well inside the 1.792 ms vblank.
- `BUSY` rises with the first `SRC_RD` and falls the clock after the last `DST_WE`.
- `SRC_ACK` is ignored when `SRC_RD`=0.

## Configuration
- `OBJ_DMA_AUTO_EN` defined: every VBLK rise starts a transfer regardless of `pending`. `DMA_ON` is ignored.
- `OBJ_DMA_AUTO_EN` undefined: a transfer starts only when armed by `DMA_ON`, as described in Operation.

## Structure
- Shared package `m72_pkg`:
  - state enum `obj_dma_state_t` (IDLE, READ, WRITE);
  - constant `OBJ_WORDS`=512.
- Single module; no sub-module is needed. The edge detectors are inline logic.

## Test plan
- Arm, then VBLK rise, with SRC_ACK tied high: 512 `DST_WE` pulses at addresses 0..511 and data equal to the source pattern. `BUSY` is high for 1024 cycles. `OVR`=0.
- VBLK rise without `DMA_ON`: no `SRC_RD`, `BUSY` stays 0. With `OBJ_DMA_AUTO_EN` defined: a full transfer occurs.
- `SRC_ACK` delayed 3 cycles per word: `SRC_ADDR` is held stable while waiting. Each word takes 5 cycles. Data is correct.
- `DMA_ON` pulsed at word 100 of an active transfer: the current transfer completes. A second full transfer starts on the next VBLK rise only.
- VBLK forced low at word 300 (slow ACK): `OVR` pulses once and the transfer still ends with a write at address 511.
- `RESET` asserted at word 50: `DST_WE` and `BUSY` drop immediately. After release with VBLK high, nothing starts until the next VBLK rise and a new `DMA_ON`.
